// File: rtl/dac_arbiter.sv
// Round-robin arbiter sharing one DAC SPI master between NUM_REQ requesters.
// Each grant covers one whole SPI transaction, followed by a programmable idle gap.
module dac_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DAC_WID = 24,
   parameter int GAP_WID = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [GAP_WID-1:0]         gap_cycles,
   input  logic [NUM_REQ-1:0]         req_arm,
   input  logic [NUM_REQ*DAC_WID-1:0] req_to_dac,
   output logic [NUM_REQ-1:0]         req_finished,
   output logic [DAC_WID-1:0]         req_from_dac,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       mst_arm,
   output logic [DAC_WID-1:0]         mst_to_dac,
   input  logic [DAC_WID-1:0]         mst_from_dac,
   input  logic                       mst_finished
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RELEASE,
      ST_GAP
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic                 mst_arm_q, mst_arm_d;
   logic [DAC_WID-1:0]   mst_word_q, mst_word_d;
   logic [NUM_REQ-1:0]   fin_q, fin_d;
   logic [DAC_WID-1:0]   rdback_q, rdback_d;
   logic [GAP_WID-1:0]   gap_cnt_q, gap_cnt_d;
   logic [GAP_WID-1:0]   gap_lat_q, gap_lat_d;

   logic [DAC_WID-1:0]   req_word [NUM_REQ];
   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     cand_idx;
   logic                 owner_armed;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_to_dac[gi*DAC_WID +: DAC_WID];
   end

   // First armed requester strictly after the last owner, wrapping around.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
         if (!pick_found && req_arm[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   assign owner_armed = |(req_arm & grant_q);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      mst_arm_d  = mst_arm_q;
      mst_word_d = mst_word_q;
      fin_d      = fin_q;
      rdback_d   = rdback_q;
      gap_cnt_d  = gap_cnt_q;
      gap_lat_d  = gap_lat_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d    = ST_BUSY;
               grant_d    = NUM_REQ'(1) << pick_idx;
               last_d     = pick_idx;
               mst_word_d = req_word[pick_idx];
               mst_arm_d  = 1'b1;
            end
         end
         ST_BUSY: begin
            if (mst_finished) begin
               rdback_d  = mst_from_dac;
               mst_arm_d = 1'b0;
               if (owner_armed) begin
                  fin_d   = grant_q;
                  state_d = ST_RELEASE;
               end else begin
                  // Owner gave up mid-transfer: no finished pulse, straight to the gap.
                  grant_d   = '0;
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
                  gap_lat_d = gap_cycles;
               end
            end
         end
         ST_RELEASE: begin
            if (!owner_armed) begin
               fin_d     = '0;
               grant_d   = '0;
               state_d   = ST_GAP;
               gap_cnt_d = '0;
               gap_lat_d = gap_cycles;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == gap_lat_q) begin
               if (!mst_finished) state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_WID'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         last_q     <= IDX_W'(NUM_REQ - 1);
         mst_arm_q  <= 1'b0;
         mst_word_q <= '0;
         fin_q      <= '0;
         rdback_q   <= '0;
         gap_cnt_q  <= '0;
         gap_lat_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         mst_arm_q  <= mst_arm_d;
         mst_word_q <= mst_word_d;
         fin_q      <= fin_d;
         rdback_q   <= rdback_d;
         gap_cnt_q  <= gap_cnt_d;
         gap_lat_q  <= gap_lat_d;
      end
   end

   assign req_finished = fin_q;
   assign req_from_dac = rdback_q;
   assign grant        = grant_q;
   assign mst_arm      = mst_arm_q;
   assign mst_to_dac   = mst_word_q;

endmodule
